// File: rtl/ov_7670_pkg.sv
// Shared types and default sizing for the OV7670 frame writer.
package ov_7670_pkg;

    localparam int unsigned OV_ADDR_W     = 19;
    localparam int unsigned OV_DATA_W     = 24;
    localparam int unsigned OV_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_STREAM     = 2'd2,
        ST_DRAIN      = 2'd3
    } fw_state_e;

endpackage

// File: rtl/ov_7670_sync_fifo.sv
// Single-clock FWFT FIFO; exposes the head and the entry behind it so the
// writer's output stage can advance by one entry per cycle.
module ov_7670_sync_fifo #(
    parameter int unsigned WIDTH = 43,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [WIDTH-1:0]         head_o,
    output logic [WIDTH-1:0]         head_next_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0] rd_idx_next_s;

    // Pointer arithmetic, flags and head lookahead.
    always_comb begin
        wr_ptr_d      = push_i ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d      = pop_i  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        empty_o       = (wr_ptr_q == rd_ptr_q);
        full_o        = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                        (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
        level_o       = wr_ptr_q - rd_ptr_q;
        rd_idx_next_s = rd_ptr_q[IDX_W-1:0] + IDX_W'(1);
        head_o        = mem_q[rd_ptr_q[IDX_W-1:0]];
        head_next_o   = mem_q[rd_idx_next_s];
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; a push into a full FIFO is only issued alongside a pop, so it
    // overwrites the slot being retired.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/ov_7670_frame_writer.sv
// Buffers captured OV7670 pixels and writes them to memory frame by frame.
// Optional drop counter: define OV7670_FRAME_WRITER_DROP_CNT_EN.
module ov_7670_frame_writer
    import ov_7670_pkg::*;
#(
    parameter int unsigned ADDR_W     = OV_ADDR_W,
    parameter int unsigned DATA_W     = OV_DATA_W,
    parameter int unsigned FIFO_DEPTH = OV_FIFO_DEPTH
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              capture_en,
    input  logic              vsync,
    input  logic [ADDR_W-1:0] pix_addr,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic              mem_waitrequest,
    output logic              frame_done,
    output logic              overflow,
    output logic              busy
`ifdef OV7670_FRAME_WRITER_DROP_CNT_EN
   ,output logic [15:0]       drop_count
`endif
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH) + 1;

    fw_state_e         state_q, state_d;
    logic              vsync_q, vsync_d;
    logic              overflow_q, overflow_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic               pop_s, push_s, drop_s, arm_s, drain_done_s;
    logic               fifo_full_s, fifo_empty_s;
    logic [PTR_W-1:0]   fifo_level_s;
    logic [ENTRY_W-1:0] fifo_head_s, fifo_head_next_s, next_entry_s;

    ov_7670_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (pclk),
        .rst         (reset),
        .push_i      (push_s),
        .pop_i       (pop_s),
        .din_i       ({pix_addr, pix_data}),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .level_o     (fifo_level_s),
        .head_o      (fifo_head_s),
        .head_next_o (fifo_head_next_s)
    );

    // Frame FSM, FIFO admission and the registered memory-bus stage.
    always_comb begin
        pop_s        = mem_write_q && !mem_waitrequest;
        push_s       = (state_q == ST_STREAM) && pix_we && (!fifo_full_s || pop_s);
        drop_s       = (state_q == ST_STREAM) && pix_we && fifo_full_s && !pop_s;
        arm_s        = (state_q == ST_IDLE) && capture_en;
        drain_done_s = (state_q == ST_DRAIN) && fifo_empty_s && !mem_write_q;
        vsync_d      = vsync;

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (capture_en) state_d = ST_WAIT_FRAME;
                else            state_d = ST_IDLE;
            end
            ST_WAIT_FRAME: begin
                if (vsync_q && !vsync) state_d = ST_STREAM;
                else                   state_d = ST_WAIT_FRAME;
            end
            ST_STREAM: begin
                if (!vsync_q && vsync) state_d = ST_DRAIN;
                else                   state_d = ST_STREAM;
            end
            ST_DRAIN: begin
                if (drain_done_s) state_d = capture_en ? ST_WAIT_FRAME : ST_IDLE;
                else              state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase

        overflow_d   = arm_s ? 1'b0 : (overflow_q || drop_s);
        frame_done_d = drain_done_s;
        busy_d       = (state_d != ST_IDLE);

        // A retiring head is replaced by the entry behind it so back-to-back
        // writes run at one per cycle; pixels pushed this cycle show next time.
        next_entry_s = pop_s ? fifo_head_next_s : fifo_head_s;
        if (!mem_write_q || pop_s) begin
            mem_write_d = pop_s ? (fifo_level_s >= PTR_W'(2)) : (fifo_level_s != PTR_W'(0));
            mem_addr_d  = next_entry_s[ENTRY_W-1 -: ADDR_W];
            mem_wdata_d = next_entry_s[DATA_W-1:0];
        end else begin
            mem_write_d = mem_write_q;
            mem_addr_d  = mem_addr_q;
            mem_wdata_d = mem_wdata_q;
        end
    end

    // Control and bus registers.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            vsync_q      <= 1'b0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign busy       = busy_q;

`ifdef OV7670_FRAME_WRITER_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of pixels lost to a full FIFO.
    always_comb begin
        if (arm_s)                                  drop_cnt_d = 16'd0;
        else if (drop_s && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
        else                                        drop_cnt_d = drop_cnt_q;
    end

    // Drop counter register.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) drop_cnt_q <= 16'd0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule
